// File: rtl/wb_stream_reader_pkg.sv
// Shared definitions for the Wishbone stream reader: FSM encoding, bus constants
// and a small address helper.
package wb_stream_reader_pkg;

    // Fixed encodings kept so state values stay comparable with older dumps.
    localparam logic [1:0] IDLE_ENC  = 2'd0;
    localparam logic [1:0] REQ_ENC   = 2'd1;
    localparam logic [1:0] GAP_ENC   = 2'd2;
    localparam logic [1:0] DRAIN_ENC = 2'd3;

    typedef enum logic [1:0] {
        IDLE  = IDLE_ENC,
        REQ   = REQ_ENC,
        GAP   = GAP_ENC,
        DRAIN = DRAIN_ENC
    } state_e;

    localparam logic [31:0] ADR_INC  = 32'd4;
    localparam logic [3:0]  SEL_MASK = 4'hF;

    function automatic logic [31:0] word_align(input logic [31:0] adr);
        return {adr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/wb_stream_reader_fifo.sv
// Synchronous first-word-fall-through FIFO with flush; DEPTH must be a power of 2.
module sync_fifo_wb #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 8
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       flush_i,
    input  logic                       wr_en_i,
    input  logic [WIDTH-1:0]           wr_data_i,
    input  logic                       rd_en_i,
    output logic [WIDTH-1:0]           rd_data_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH):0]     count_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW-1:0] PTR_ONE   = 1;
    localparam logic [AW:0]   CNT_ONE   = 1;
    localparam logic [AW:0]   DEPTH_CNT = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             do_wr;
    logic             do_rd;

    assign full_o    = (count_q == DEPTH_CNT);
    assign empty_o   = (count_q == '0);
    assign count_o   = count_q;
    assign rd_data_o = mem_q[rd_ptr_q];

    assign do_wr = wr_en_i && !full_o && !flush_i;
    assign do_rd = rd_en_i && !empty_o && !flush_i;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_wr) begin
                wr_ptr_d = wr_ptr_q + PTR_ONE;
            end
            if (do_rd) begin
                rd_ptr_d = rd_ptr_q + PTR_ONE;
            end
            unique case ({do_wr, do_rd})
                2'b10:   count_d = count_q + CNT_ONE;
                2'b01:   count_d = count_q - CNT_ONE;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage carries no reset; occupancy alone decides what is valid.
    always_ff @(posedge clk_i) begin
        if (do_wr) begin
            mem_q[wr_ptr_q] <= wr_data_i;
        end
    end

endmodule

// File: rtl/wb_stream_reader.sv
// Wishbone classic read master that fetches len_i consecutive words from
// base_adr_i and presents them on a valid/ready stream through a small FIFO.
module wb_stream_reader
    import wb_stream_reader_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 8,
    parameter int unsigned LEN_W      = 16
) (
    input  logic             wb_clk_i,
    input  logic             wb_rst_i,
    input  logic             start_i,
    input  logic [31:0]      base_adr_i,
    input  logic [LEN_W-1:0] len_i,
    output logic             busy_o,
    output logic             done_o,
    output logic             err_o,
    output logic [31:0]      wb_adr_o,
    input  logic [31:0]      wb_dat_i,
    output logic [3:0]       wb_sel_o,
    output logic             wb_we_o,
    output logic             wb_cyc_o,
    output logic             wb_stb_o,
    input  logic             wb_ack_i,
    input  logic             wb_err_i,
    output logic [31:0]      m_data_o,
    output logic             m_valid_o,
    input  logic             m_ready_i
);

    localparam int unsigned   CW      = $clog2(FIFO_DEPTH) + 1;
    localparam logic [LEN_W-1:0] LEN_ONE = 1;

    state_e           state_q, state_d;
    logic [31:0]      adr_q, adr_d;
    logic [LEN_W-1:0] cnt_q, cnt_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             err_q, err_d;

    logic             bus_req;
    logic             fifo_wr;
    logic             fifo_flush;
    logic             fifo_full;
    logic             fifo_empty;
    logic [CW-1:0]    fifo_count;

    // A request is only raised when the word it returns is guaranteed a slot.
    assign bus_req   = (state_q == REQ) && !fifo_full;

    assign wb_cyc_o  = bus_req;
    assign wb_stb_o  = bus_req;
    assign wb_adr_o  = adr_q;
    assign wb_sel_o  = SEL_MASK;
    assign wb_we_o   = 1'b0;

    assign busy_o    = busy_q;
    assign done_o    = done_q;
    assign err_o     = err_q;
    assign m_valid_o = !fifo_empty;

    sync_fifo_wb #(
        .WIDTH (32),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i     (wb_clk_i),
        .rst_i     (wb_rst_i),
        .flush_i   (fifo_flush),
        .wr_en_i   (fifo_wr),
        .wr_data_i (wb_dat_i),
        .rd_en_i   (m_ready_i),
        .rd_data_o (m_data_o),
        .full_o    (fifo_full),
        .empty_o   (fifo_empty),
        .count_o   (fifo_count)
    );

    always_comb begin
        state_d    = state_q;
        adr_d      = adr_q;
        cnt_d      = cnt_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        err_d      = err_q;
        fifo_wr    = 1'b0;
        fifo_flush = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (start_i) begin
                    adr_d   = word_align(base_adr_i);
                    cnt_d   = len_i;
                    err_d   = 1'b0;
                    busy_d  = 1'b1;
                    state_d = (len_i == '0) ? DRAIN : REQ;
                end
            end
            REQ: begin
                // Error wins over a coincident ack; its data is dropped.
                if (bus_req && wb_err_i) begin
                    err_d      = 1'b1;
                    fifo_flush = 1'b1;
                    state_d    = DRAIN;
                end else if (bus_req && wb_ack_i) begin
                    fifo_wr = 1'b1;
                    adr_d   = adr_q + ADR_INC;
                    cnt_d   = cnt_q - LEN_ONE;
                    state_d = (cnt_q == LEN_ONE) ? DRAIN : GAP;
                end
            end
            GAP: begin
                state_d = REQ;
            end
            DRAIN: begin
                if (fifo_count == '0) begin
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q <= IDLE;
            adr_q   <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            adr_q   <= adr_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

endmodule
